// File: rtl/dir_input_ctrl.sv
// Direction input controller for the snake game: synchronizes and debounces four
// push-buttons, arbitrates simultaneous presses and holds the current direction.
module dir_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [1:0] dir,
    output logic       dir_changed
);

    // Bit index of every per-button vector equals the direction code.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       db;
    logic [3:0]       db_prev;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       onehot_q;
    logic             cand_valid;
    logic [1:0]       cand;
    logic             accept;

    function automatic logic [3:0] decode(input logic [1:0] d);
        decode = 4'b0001 << d;
    endfunction

    assign raw = {right_i, left_i, down_i, up_i};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which the synchronizer relies on.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // NOTE: the counter array is cleared in reset like any other register;
    // a partial count must never survive a reset pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            db      <= '0;
            db_prev <= '0;
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            db_prev <= db;
            for (int b = 0; b < 4; b++) begin
                if (s2[b] == db[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    db[b]  <= s2[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    // Only rising debounced edges count as presses.
    assign press = db & ~db_prev;

    // NOTE: defaults first, so no path through this block leaves a latch.
    always_comb begin
        cand_valid = 1'b1;
        cand       = DIR_UP;
        if (press[DIR_UP]) begin
            cand = DIR_UP;
        end else if (press[DIR_DOWN]) begin
            cand = DIR_DOWN;
        end else if (press[DIR_LEFT]) begin
            cand = DIR_LEFT;
        end else if (press[DIR_RIGHT]) begin
            cand = DIR_RIGHT;
        end else begin
            cand_valid = 1'b0;
        end
    end

    // Flipping bit 0 of a code yields its reverse (up/down, left/right).
    assign accept = cand_valid && (cand != dir) && (cand != (dir ^ 2'b01));

    always_ff @(posedge clk) begin
        if (reset) begin
            dir         <= DIR_RIGHT;
            onehot_q    <= decode(DIR_RIGHT);
            dir_changed <= 1'b0;
        end else begin
            dir_changed <= accept;
            if (accept) begin
                dir      <= cand;
                onehot_q <= decode(cand);
            end
        end
    end

    assign {right, left, down, up} = onehot_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl: directed scenarios plus random button traffic, checked
// against a window-based debounce model and a scoreboard of expected direction changes.
module tb_dir_input_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       up_i, down_i, left_i, right_i;
    logic       up, down, left, right;
    logic [1:0] dir;
    logic       dir_changed;

    dir_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .up_i       (up_i),
        .down_i     (down_i),
        .left_i     (left_i),
        .right_i    (right_i),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .dir        (dir),
        .dir_changed(dir_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         pulse_cnt = 0;
    int         gcyc = 0;
    bit         mon_en = 0;
    logic [1:0] exp_dir = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, act, req, gcyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a button's debounced level flips once the synchronized
    // sample (raw delayed two edges) has disagreed with it for the last D edges,
    // none of which precede the previous flip or reset. A rise is seen as a
    // press one edge later.
    bit hist[4][$];
    int last_evt[4];
    bit mdb[4];
    bit rise_pend[4];
    int e_cnt;

    always @(posedge clk) begin
        logic [3:0] rawv;
        int         win;
        bit         all_diff;
        gcyc++;
        if (reset) begin
            exp_dir = 2'b11;
            e_cnt   = 0;
            for (int b = 0; b < 4; b++) begin
                hist[b]      = {1'b0, 1'b0};
                last_evt[b]  = 0;
                mdb[b]       = 1'b0;
                rise_pend[b] = 1'b0;
            end
        end else begin
            e_cnt++;
            win = -1;
            for (int b = 0; b < 4; b++) begin
                if (rise_pend[b] && win < 0) win = b;
            end
            if (win >= 0 && win[1:0] != exp_dir && win[1:0] != (exp_dir ^ 2'b01)) begin
                exp_dir = win[1:0];
                sb.push_back('{win[1:0], gcyc});
            end
            rawv = {right_i, left_i, down_i, up_i};
            for (int b = 0; b < 4; b++) begin
                hist[b].push_front(rawv[b]);
                rise_pend[b] = 1'b0;
                if (e_cnt - last_evt[b] >= D) begin
                    all_diff = 1'b1;
                    for (int i = 0; i < D; i++) begin
                        if (hist[b][2+i] == mdb[b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        mdb[b]       = ~mdb[b];
                        last_evt[b]  = e_cnt;
                        rise_pend[b] = mdb[b];
                    end
                end
                if (hist[b].size() > 16) void'(hist[b].pop_back());
            end
        end
    end

    // Monitor: per-cycle direction check, and a scoreboard pop on every pulse.
    always @(negedge clk) begin
        exp_t ent;
        if (mon_en) begin
            check("dir", dir, exp_dir);
            check("onehot", {right, left, down, up}, 4'b0001 << exp_dir);
            while (sb.size() > 0 && sb[0].cyc < gcyc) begin
                total++;
                bad++;
                $display("FAIL missed_pulse: got no dir_changed required pulse for dir=%0d at cycle %0d",
                         sb[0].d, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (dir_changed) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got dir_changed=1 required=0 (cycle %0d)", gcyc);
                end else begin
                    ent = sb.pop_front();
                    check("chg_dir", dir, ent.d);
                    check("chg_cycle", gcyc, ent.cyc);
                end
            end
        end
    end

    task automatic set_btn(input logic [3:0] v);
        {right_i, left_i, down_i, up_i} = v;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        set_btn(4'b0000);
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] mask;
        logic [3:0] v;
        logic [8:0] bounce;
        int         len;

        reset = 1'b1;
        set_btn(4'b0000);
        tick(1);
        mon_en = 1'b1;

        // Reset then idle
        do_reset(2);
        pulse_cnt = 0;
        tick(20);
        check("idle_dir", dir, 2'b11);
        check("idle_onehot", {right, left, down, up}, 4'b1000);
        check("idle_pulses", pulse_cnt, 0);

        // Single press: exact latency, single pulse while held
        do_reset(2);
        pulse_cnt = 0;
        up_i = 1'b1;
        tick(6);
        check("up_edge6_dir", dir, 2'b11);
        tick(1);
        check("up_edge7_dir", dir, 2'b00);
        check("up_edge7_up", up, 1'b1);
        check("up_edge7_pulse", dir_changed, 1'b1);
        tick(1);
        check("up_edge8_pulse", dir_changed, 1'b0);
        tick(50);
        check("up_held_pulses", pulse_cnt, 1);
        up_i = 1'b0;
        tick(10);

        // Short glitch, then held reverse direction
        do_reset(2);
        pulse_cnt = 0;
        left_i = 1'b1;
        tick(3);
        left_i = 1'b0;
        tick(15);
        check("glitch_dir", dir, 2'b11);
        left_i = 1'b1;
        tick(20);
        check("reverse_dir", dir, 2'b11);
        check("reverse_pulses", pulse_cnt, 0);
        left_i = 1'b0;
        tick(10);

        // Simultaneous up+down resolves to up, then left
        do_reset(2);
        pulse_cnt = 0;
        up_i   = 1'b1;
        down_i = 1'b1;
        tick(12);
        check("prio_dir", dir, 2'b00);
        check("prio_pulses", pulse_cnt, 1);
        up_i   = 1'b0;
        down_i = 1'b0;
        tick(4);
        left_i = 1'b1;
        tick(6);
        check("left_edge6_dir", dir, 2'b00);
        tick(1);
        check("left_edge7_dir", dir, 2'b10);
        check("left_edge7_pulse", dir_changed, 1'b1);
        left_i = 1'b0;
        tick(10);

        // Reset in the middle of a debounce, button held across release
        do_reset(2);
        up_i = 1'b1;
        tick(10);
        up_i = 1'b0;
        tick(10);
        check("pre_rst_dir", dir, 2'b00);
        down_i = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_dir", dir, 2'b11);
        pulse_cnt = 0;
        tick(6);
        check("post_rst_edge6_dir", dir, 2'b11);
        tick(1);
        check("post_rst_edge7_dir", dir, 2'b01);
        check("post_rst_pulse", dir_changed, 1'b1);
        tick(10);
        check("post_rst_pulses", pulse_cnt, 1);
        down_i = 1'b0;
        tick(10);

        // Bounce on right: timed from the last rising transition
        do_reset(2);
        up_i = 1'b1;
        tick(10);
        up_i = 1'b0;
        tick(10);
        pulse_cnt = 0;
        bounce = 9'b111101101;
        for (int i = 0; i < 9; i++) begin
            right_i = bounce[i];
            tick(1);
        end
        tick(2);
        check("bounce_edge6_dir", dir, 2'b00);
        tick(1);
        check("bounce_edge7_dir", dir, 2'b11);
        tick(20);
        check("bounce_pulses", pulse_cnt, 1);
        right_i = 1'b0;
        tick(10);

        // Random traffic with occasional chatter and resets
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 1) == 0) mask = 4'b0001 << $urandom_range(0, 3);
            else                           mask = 4'($urandom_range(1, 15));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                for (int b = 0; b < 4; b++) begin
                    v[b] = mask[b] && ($urandom_range(0, 9) != 0);
                end
                set_btn(v);
                tick(1);
            end
            set_btn(4'b0000);
            tick($urandom_range(0, 8));
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
        end

        set_btn(4'b0000);
        tick(20);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dir_input_ctrl.md
DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive cycles a synchronized button level must differ from its debounced level before it is accepted (legal range 2..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 18, meaning the width of each debounce counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports up_i, down_i, left_i, right_i  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 SHALL have ports up, down, left, right  output  1 each  registered one-hot current direction, feeding the snake game's direction inputs.
REQ-007 SHALL have port dir  output  2  encoded current direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 SHALL have port dir_changed  output  1  one-cycle pulse, high in the cycle dir first shows a new value.

Function
REQ-009 SHALL pass each raw button through a dedicated 2-flop synchronizer (s1, s2); no other logic SHALL sample raw inputs.
REQ-010 SHALL keep, per button, a debounced level db and a CNT_W-bit counter cnt: if s2 == db then cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1 then db <= s2, cnt <= 0; else cnt <= cnt+1.
REQ-011 SHALL treat any s2 return to db before acceptance as a glitch: counter clears, db unchanged.
REQ-012 SHALL register db_prev per button and form press = db & ~db_prev; release edges SHALL generate nothing.
REQ-013 SHALL, with raw input changed before edge 1 and held, raise db at edge DEBOUNCE_CYCLES+2 and update dir at edge DEBOUNCE_CYCLES+3 (fixed latency, no jitter).
REQ-014 SHALL resolve simultaneous presses in one cycle by fixed priority up > down > left > right; only the winning candidate is evaluated, losers are discarded (not queued).
REQ-015 SHALL reject a candidate that is the exact reverse of the current dir (up/down, left/right); dir unchanged, no dir_changed.
REQ-016 SHALL ignore a candidate equal to the current dir; no dir_changed.
REQ-017 SHALL, when the winning candidate is accepted, load dir and the one-hot outputs at the same edge and assert dir_changed for exactly that one cycle.
REQ-018 SHALL keep the one-hot outputs exactly one-hot and equal to decode(dir) in every cycle.
REQ-019 SHALL hold dir indefinitely with no press; a held button SHALL produce only one press.

Reset
REQ-020 SHALL, while reset is sampled high, clear s1, s2, db, db_prev, cnt for all buttons, set dir = 11 (right), right = 1, up/down/left = 0, dir_changed = 0.
REQ-021 SHALL discard any debounce in progress when reset asserts mid-count; no partial count survives.
REQ-022 SHALL, for a button held across reset release, treat it as a fresh press accepted DEBOUNCE_CYCLES+3 edges after the first edge with reset low (subject to REQ-014..016).

Verification (DEBOUNCE_CYCLES = 4)
REQ-023 Reset then idle 20 cycles -> dir = 11, right = 1, others 0, dir_changed never high.
REQ-024 up_i high before edge 1, held -> dir = 00 and up = 1 at edge 7, dir_changed high for that single cycle only; held 50 more cycles -> no further pulse.
REQ-025 From dir = 11: left_i high 3 cycles then low -> no change; left_i high held -> rejected as reverse, dir stays 11, no pulse.
REQ-026 From dir = 11: up_i and down_i raised same edge and held -> dir = 00 (priority), one pulse; then left_i pressed -> dir = 10 after 7 edges.
REQ-027 From dir = 00: down_i held, reset asserted at debounce cycle 2 for one cycle, still held -> dir = 11 after reset, then down accepted (01) 7 edges after reset release, one pulse.
REQ-028 Bounce pattern on right_i from dir = 00 (1,0,1,1,0,1,1,1,1 per cycle, then held 1) -> exactly one accepted change to 11, timed from the last 0->1 transition.
